// File: rtl/spike_event_sender.sv
// spike_event_sender
//   Transmit end of the spike event bus. Per-channel on/off request pulses are
//   latched as pending flags, arbitrated round-robin (one grant per cycle) into
//   an event FIFO, and drained onto the bus with at least min_gap idle cycles
//   between consecutive spike_valid strobes.
//
//   Optional build macro: SPIKE_SENDER_TIMESTAMP_EN
//     When defined, a free-running 16-bit cycle counter is sampled at grant
//     time, stored with each FIFO entry and presented on spike_time together
//     with spike_valid.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high reset
//   on_req         per-channel on-event request, sampled every clk
//   off_req        per-channel off-event request, sampled every clk
//   min_gap        idle cycles enforced between consecutive spike_valid pulses
//   spike_valid    one-cycle event strobe
//   spike_address  event address (BASE_ADDRESS + channel), valid with spike_valid
//   spike_on_off   1 = on event, 0 = off event
//   fifo_count     current FIFO occupancy
//   drop_count     saturating count of dropped requests
//   busy           any pending flag set or FIFO non-empty
//   spike_time     (timestamp build only) grant-time cycle stamp of the event

module spike_event_sender #(
    parameter int NUM_CHANNELS = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int BASE_ADDRESS = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CHANNELS-1:0]       on_req,
    input  logic [NUM_CHANNELS-1:0]       off_req,
    input  logic [7:0]                    min_gap,
    output logic                          spike_valid,
    output logic [ADDR_WIDTH-1:0]         spike_address,
    output logic                          spike_on_off,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   drop_count,
    output logic                          busy
`ifdef SPIKE_SENDER_TIMESTAMP_EN
    ,
    output logic [15:0]                   spike_time
`endif
);

    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef SPIKE_SENDER_TIMESTAMP_EN
    localparam int ENTRY_W = ADDR_WIDTH + 1 + 16;
`else
    localparam int ENTRY_W = ADDR_WIDTH + 1;
`endif

    function automatic logic [15:0] sat16(input logic [16:0] value);
        return value[16] ? 16'hFFFF : value[15:0];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] chan_addr(input logic [CH_W-1:0] ch);
        logic [31:0] full_addr;
        full_addr = 32'(BASE_ADDRESS) + 32'(ch);
        return full_addr[ADDR_WIDTH-1:0];
    endfunction

    logic [NUM_CHANNELS-1:0] pend_on;
    logic [NUM_CHANNELS-1:0] pend_off;
    logic [CH_W-1:0]         rr_ptr;
    logic [CH_W-1:0]         ptr_next;

    logic                    grant_vld;
    logic [CH_W-1:0]         grant_ch;
    logic                    grant_pol;
    logic [NUM_CHANNELS-1:0] grant_on_vec;
    logic [NUM_CHANNELS-1:0] grant_off_vec;

    logic [NUM_CHANNELS-1:0] drop_on;
    logic [NUM_CHANNELS-1:0] drop_off;
    logic [7:0]              drop_inc;
    logic [16:0]             drop_sum;

    logic [ENTRY_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic [ENTRY_W-1:0]      push_entry;
    logic [ENTRY_W-1:0]      pop_entry;

    logic [7:0]              gap_cnt;

`ifdef SPIKE_SENDER_TIMESTAMP_EN
    logic [15:0]             time_cnt;

    always_ff @(posedge clk) begin
        if (reset) time_cnt <= '0;
        else       time_cnt <= time_cnt + 16'd1;
    end
`endif

    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign pop        = !fifo_empty && (gap_cnt == 8'd0);
    assign push       = grant_vld;
    assign busy       = (|pend_on) || (|pend_off) || !fifo_empty;

    // ---- arbitration: first channel with any pending flag, from rr_ptr ----
    always_comb begin
        logic [CH_W-1:0] idx;
        int              raw;
        grant_vld = 1'b0;
        grant_ch  = '0;
        grant_pol = 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            raw = int'(rr_ptr) + k;
            if (raw >= NUM_CHANNELS) raw = raw - NUM_CHANNELS;
            idx = CH_W'(raw);
            if (!grant_vld && (pend_on[idx] || pend_off[idx])) begin
                grant_vld = 1'b1;
                grant_ch  = idx;
                grant_pol = pend_on[idx];
            end
        end
        // A full FIFO only accepts a push when it is popped in the same cycle.
        if (fifo_full && !pop) grant_vld = 1'b0;
    end

    always_comb begin
        grant_on_vec  = '0;
        grant_off_vec = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            grant_on_vec[i]  = grant_vld &&  grant_pol && (grant_ch == CH_W'(i));
            grant_off_vec[i] = grant_vld && !grant_pol && (grant_ch == CH_W'(i));
        end
    end

    // Stay on the channel while its off flag still waits behind a granted on.
    always_comb begin
        if (grant_pol && pend_off[grant_ch])
            ptr_next = grant_ch;
        else if (grant_ch == CH_W'(NUM_CHANNELS - 1))
            ptr_next = '0;
        else
            ptr_next = grant_ch + CH_W'(1);
    end

    // ---- capture: a request against a still-set, ungranted flag is a drop ----
    assign drop_on  = on_req  & pend_on  & ~grant_on_vec;
    assign drop_off = off_req & pend_off & ~grant_off_vec;

    always_comb begin
        drop_inc = '0;
        for (int i = 0; i < NUM_CHANNELS; i++)
            drop_inc = drop_inc + 8'(drop_on[i]) + 8'(drop_off[i]);
    end

    assign drop_sum = {1'b0, drop_count} + {9'b0, drop_inc};

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_on    <= '0;
            pend_off   <= '0;
            rr_ptr     <= '0;
            drop_count <= '0;
        end else begin
            pend_on    <= (pend_on  & ~grant_on_vec)  | on_req;
            pend_off   <= (pend_off & ~grant_off_vec) | off_req;
            drop_count <= sat16(drop_sum);
            if (grant_vld) rr_ptr <= ptr_next;
        end
    end

    // ---- event FIFO ----
`ifdef SPIKE_SENDER_TIMESTAMP_EN
    assign push_entry = {chan_addr(grant_ch), grant_pol, time_cnt};
`else
    assign push_entry = {chan_addr(grant_ch), grant_pol};
`endif
    assign pop_entry = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // ---- output register and inter-event gap counter ----
    always_ff @(posedge clk) begin
        if (reset) begin
            spike_valid   <= 1'b0;
            spike_address <= '0;
            spike_on_off  <= 1'b0;
            gap_cnt       <= '0;
`ifdef SPIKE_SENDER_TIMESTAMP_EN
            spike_time    <= '0;
`endif
        end else if (pop) begin
            spike_valid   <= 1'b1;
`ifdef SPIKE_SENDER_TIMESTAMP_EN
            spike_address <= pop_entry[ENTRY_W-1 -: ADDR_WIDTH];
            spike_on_off  <= pop_entry[16];
            spike_time    <= pop_entry[15:0];
`else
            spike_address <= pop_entry[ENTRY_W-1 -: ADDR_WIDTH];
            spike_on_off  <= pop_entry[0];
`endif
            gap_cnt       <= min_gap;
        end else begin
            spike_valid   <= 1'b0;
            if (gap_cnt != 8'd0) gap_cnt <= gap_cnt - 8'd1;
        end
    end

endmodule

// File: tb/tb_spike_event_sender.sv
module tb_spike_event_sender;

    localparam int N     = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 16;
    localparam int BASE  = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int VW    = 1 + AW + 1 + CW + 16 + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  on_req = '0;
    logic [N-1:0]  off_req = '0;
    logic [7:0]    min_gap = '0;
    logic          spike_valid;
    logic [AW-1:0] spike_address;
    logic          spike_on_off;
    logic [CW-1:0] fifo_count;
    logic [15:0]   drop_count;
    logic          busy;
`ifdef SPIKE_SENDER_TIMESTAMP_EN
    logic [15:0]   spike_time;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    spike_event_sender #(
        .NUM_CHANNELS(N),
        .ADDR_WIDTH  (AW),
        .FIFO_DEPTH  (DEPTH),
        .BASE_ADDRESS(BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .on_req       (on_req),
        .off_req      (off_req),
        .min_gap      (min_gap),
        .spike_valid  (spike_valid),
        .spike_address(spike_address),
        .spike_on_off (spike_on_off),
        .fifo_count   (fifo_count),
        .drop_count   (drop_count),
        .busy         (busy)
`ifdef SPIKE_SENDER_TIMESTAMP_EN
        ,
        .spike_time   (spike_time)
`endif
    );

    // Reference model: pending flags as bit arrays, FIFO as a queue of events.
    typedef struct {
        int addr;
        bit pol;
    } ev_t;

    bit  m_pon [N];
    bit  m_poff[N];
    int  m_ptr;
    ev_t m_q[$];
    int  m_gap;
    bit  m_valid;
    int  m_addr;
    bit  m_pol;
    int  m_drops;

    always @(posedge clk) begin : model
        bit  do_pop;
        bit  can_push;
        int  g;
        int  c;
        bit  gpol;
        ev_t e;
        cyc = cyc + 1;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_pon[i]  = 1'b0;
                m_poff[i] = 1'b0;
            end
            m_ptr = 0;
            m_q.delete();
            m_gap = 0;
            m_valid = 1'b0;
            m_addr = 0;
            m_pol = 1'b0;
            m_drops = 0;
        end else begin
            do_pop   = (m_q.size() > 0) && (m_gap == 0);
            can_push = (m_q.size() < DEPTH) || do_pop;
            g = -1;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (g < 0 && (m_pon[c] || m_poff[c])) g = c;
            end
            if (!can_push) g = -1;
            if (do_pop) begin
                e = m_q.pop_front();
                m_valid = 1'b1;
                m_addr = e.addr;
                m_pol = e.pol;
                m_gap = int'(min_gap);
            end else begin
                m_valid = 1'b0;
                if (m_gap > 0) m_gap = m_gap - 1;
            end
            if (g >= 0) begin
                gpol = m_pon[g];
                e.addr = (BASE + g) % (1 << AW);
                e.pol = gpol;
                m_q.push_back(e);
                m_ptr = (gpol && m_poff[g]) ? g : (g + 1) % N;
                if (gpol) m_pon[g] = 1'b0;
                else      m_poff[g] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (on_req[i]) begin
                    if (m_pon[i]) m_drops = m_drops + 1;
                    m_pon[i] = 1'b1;
                end
                if (off_req[i]) begin
                    if (m_poff[i]) m_drops = m_drops + 1;
                    m_poff[i] = 1'b1;
                end
            end
            if (m_drops > 65535) m_drops = 65535;
        end
    end

    function automatic logic [VW-1:0] dut_vec();
        logic [AW-1:0] a;
        a = spike_valid ? spike_address : '0;
        return {spike_valid, a, spike_valid & spike_on_off, fifo_count, drop_count, busy};
    endfunction

    function automatic logic [VW-1:0] mdl_vec();
        bit            b;
        logic [AW-1:0] a;
        b = (m_q.size() > 0);
        for (int i = 0; i < N; i++) b = b | m_pon[i] | m_poff[i];
        a = m_valid ? AW'(m_addr) : '0;
        return {m_valid, a, m_valid & m_pol, CW'(m_q.size()), 16'(m_drops), b};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        on_req = '0;
        off_req = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({spike_valid, spike_address, spike_on_off, fifo_count, drop_count, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b a=%h o=%b cnt=%0d drop=%0d busy=%b, want all zero",
                     spike_valid, spike_address, spike_on_off, fifo_count, drop_count, busy);
        end
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            errors++;
            $display("FAIL reset_model: got %h want %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_latency(input string tag);
        min_gap = 8'd0;
        on_req = 8'h08;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            on_req = '0;
            checks++;
            if (spike_valid !== (n == 3)) begin
                errors++;
                $display("FAIL %s_valid cycle %0d: got %b want %b", tag, n, spike_valid, (n == 3));
            end
            if (n == 3) begin
                checks++;
                if ({spike_address, spike_on_off} !== {AW'(BASE + 3), 1'b1}) begin
                    errors++;
                    $display("FAIL %s_event: got addr=%0d on=%b want addr=%0d on=1",
                             tag, spike_address, spike_on_off, BASE + 3);
                end
            end
            if (n >= 3) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_busy cycle %0d: got %b want 0", tag, n, busy);
                end
            end
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL %s_model cycle %0d: got %h want %h", tag, n, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_burst();
        do_reset();
        min_gap = 8'd0;
        on_req = 8'hFF;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            on_req = '0;
            checks++;
            if (spike_valid !== (n >= 3 && n <= 10)) begin
                errors++;
                $display("FAIL burst_valid cycle %0d: got %b", n, spike_valid);
            end
            if (n >= 3 && n <= 10) begin
                checks++;
                if ({spike_address, spike_on_off} !== {AW'(BASE + n - 3), 1'b1}) begin
                    errors++;
                    $display("FAIL burst_event cycle %0d: got addr=%0d on=%b want addr=%0d on=1",
                             n, spike_address, spike_on_off, BASE + n - 3);
                end
            end
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL burst_model cycle %0d: got %h want %h", n, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (drop_count !== 16'd0) begin
            errors++;
            $display("FAIL burst_drops: got %0d want 0", drop_count);
        end
    endtask

    task automatic test_on_off_same();
        do_reset();
        min_gap = 8'd0;
        on_req = 8'h04;
        off_req = 8'h04;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            on_req = '0;
            off_req = '0;
            checks++;
            if (spike_valid !== (n == 3 || n == 4)) begin
                errors++;
                $display("FAIL onoff_valid cycle %0d: got %b", n, spike_valid);
            end
            if (n == 3 || n == 4) begin
                checks++;
                if ({spike_address, spike_on_off} !== {AW'(BASE + 2), (n == 3)}) begin
                    errors++;
                    $display("FAIL onoff_event cycle %0d: got addr=%0d on=%b want addr=%0d on=%b",
                             n, spike_address, spike_on_off, BASE + 2, (n == 3));
                end
            end
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL onoff_model cycle %0d: got %h want %h", n, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (drop_count !== 16'd0) begin
            errors++;
            $display("FAIL onoff_drops: got %0d want 0", drop_count);
        end
    endtask

    task automatic test_min_gap();
        bit want;
        do_reset();
        min_gap = 8'd3;
        on_req = 8'h0F;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            on_req = '0;
            want = (n >= 3) && (n <= 15) && ((n - 3) % 4 == 0);
            checks++;
            if (spike_valid !== want) begin
                errors++;
                $display("FAIL gap_valid cycle %0d: got %b want %b", n, spike_valid, want);
            end
            if (want) begin
                checks++;
                if (spike_address !== AW'(BASE + (n - 3) / 4)) begin
                    errors++;
                    $display("FAIL gap_addr cycle %0d: got %0d want %0d", n, spike_address, BASE + (n - 3) / 4);
                end
            end
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL gap_model cycle %0d: got %h want %h", n, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_held_request();
        int last_emit;
        int n;
        do_reset();
        min_gap = 8'd10;
        last_emit = -1;
        n = 0;
        on_req = 8'h20;
        while (n < 400 && (n < 41 || busy)) begin
            @(negedge clk);
            n++;
            if (n >= 40) on_req = '0;
            if (spike_valid) begin
                if (last_emit >= 0) begin
                    checks++;
                    if (n - last_emit !== 11) begin
                        errors++;
                        $display("FAIL hold_spacing cycle %0d: got %0d want 11", n, n - last_emit);
                    end
                end
                last_emit = n;
            end
            checks++;
            if (fifo_count > CW'(DEPTH)) begin
                errors++;
                $display("FAIL hold_fifo_bound cycle %0d: got %0d max %0d", n, fifo_count, DEPTH);
            end
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL hold_model cycle %0d: got %h want %h", n, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_drain_timeout: busy=%b after %0d cycles, want 0", busy, n);
        end
        checks++;
        if (drop_count == 16'd0 || drop_count !== 16'(m_drops)) begin
            errors++;
            $display("FAIL hold_drops: got %0d want %0d (nonzero)", drop_count, m_drops);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        min_gap = 8'd50;
        on_req = 8'hFF;
        off_req = 8'h03;
        @(negedge clk);
        off_req = '0;
        for (int n = 2; n <= 12; n++) begin
            @(negedge clk);
            on_req = '0;
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL midrst_model cycle %0d: got %h want %h", n, dut_vec(), mdl_vec());
            end
        end
        checks++;
        if (fifo_count < CW'(9) || drop_count == 16'd0) begin
            errors++;
            $display("FAIL midrst_loaded: got fifo=%0d drops=%0d want fifo>=9 drops>0", fifo_count, drop_count);
        end
        do_reset();
        checks++;
        if ({fifo_count, drop_count, busy, spike_valid} !== '0) begin
            errors++;
            $display("FAIL midrst_cleared: got fifo=%0d drops=%0d busy=%b v=%b want all 0",
                     fifo_count, drop_count, busy, spike_valid);
        end
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            checks++;
            if (spike_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst_no_spike cycle %0d: got %b want 0", n, spike_valid);
            end
        end
        test_latency("midrst_latency");
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++;
                $display("FAIL rand_model cycle %0d: got %h want %h", n, dut_vec(), mdl_vec());
            end
            if (n % 37 == 0) min_gap = 8'($urandom_range(0, 3));
            on_req  = N'($urandom & $urandom & $urandom);
            off_req = N'($urandom & $urandom & $urandom);
            reset   = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        on_req = '0;
        off_req = '0;
    endtask

    initial begin
        test_reset();
        do_reset();
        test_latency("latency");
        test_burst();
        test_on_off_same();
        test_min_gap();
        test_held_request();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
